// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP target oversampled in the CLK domain: 4-bit IR with IDCODE,
// BYPASS and a 32-bit USERDATA register, used as a loopback target for the adapter.
module jtag_tap_responder (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        TCK,
    input  logic        TMS,
    input  logic        TDI,
    input  logic        nTRST,
    output logic        TDO,
    output logic        TDO_OE,
    input  logic [31:0] USER_CAPTURE,
    output logic [31:0] USER_DR,
    output logic        USER_UPDATE,
    output logic [3:0]  TAP_STATE
);

    localparam logic [31:0] IDCODE_VALUE   = 32'h1234_5679;
    localparam logic [3:0]  INSTR_IDCODE   = 4'b1110;
    localparam logic [3:0]  INSTR_USERDATA = 4'b1000;

    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC, SEL_DR   = 4'h7, CAP_DR   = 4'h6,
        SH_DR    = 4'h2, EX1_DR   = 4'h1, PAUSE_DR = 4'h3, EX2_DR   = 4'h0,
        UPD_DR   = 4'h5, SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA,
        EX1_IR   = 4'h9, PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
    } tap_state_t;

    // Pin order in the synchronizer bank: 0 TCK, 1 TMS, 2 TDI, 3 nTRST.
    logic [3:0] pin_raw;
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic       tck_s3_reg;

    assign pin_raw = {nTRST, TDI, TMS, TCK};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= pin_raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) tck_s3_reg <= 1'b0;
        else       tck_s3_reg <= sync2_reg[0];
    end

    logic tck_rise, tck_fall, tms_s, tdi_s, trst_active;
    assign tck_rise    =  sync2_reg[0] & ~tck_s3_reg;
    assign tck_fall    = ~sync2_reg[0] &  tck_s3_reg;
    assign tms_s       =  sync2_reg[1];
    assign tdi_s       =  sync2_reg[2];
    assign trst_active = ~sync2_reg[3];

    tap_state_t state_reg, state_next;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_reg <= TLR;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (trst_active) begin
            state_next = TLR;
        end else if (tck_rise) begin
            case (state_reg)
                TLR:      state_next = tms_s ? TLR    : RTI;
                RTI:      state_next = tms_s ? SEL_DR : RTI;
                SEL_DR:   state_next = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:   state_next = tms_s ? EX1_DR : SH_DR;
                SH_DR:    state_next = tms_s ? EX1_DR : SH_DR;
                EX1_DR:   state_next = tms_s ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_next = tms_s ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_next = tms_s ? UPD_DR : SH_DR;
                UPD_DR:   state_next = tms_s ? SEL_DR : RTI;
                SEL_IR:   state_next = tms_s ? TLR    : CAP_IR;
                CAP_IR:   state_next = tms_s ? EX1_IR : SH_IR;
                SH_IR:    state_next = tms_s ? EX1_IR : SH_IR;
                EX1_IR:   state_next = tms_s ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_next = tms_s ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_next = tms_s ? UPD_IR : SH_IR;
                UPD_IR:   state_next = tms_s ? SEL_DR : RTI;
                default:  state_next = TLR;
            endcase
        end
    end

    logic [3:0]  ir_reg, ir_shift_reg;
    logic [31:0] dr_shift_reg, user_dr_reg;
    logic        tdo_reg, tdo_oe_reg, user_update_reg;
    logic        is_idcode, is_user, is_bypass;

    assign is_idcode = (ir_reg == INSTR_IDCODE);
    assign is_user   = (ir_reg == INSTR_USERDATA);
    assign is_bypass = ~is_idcode & ~is_user;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ir_reg          <= INSTR_IDCODE;
            ir_shift_reg    <= 4'b0000;
            dr_shift_reg    <= 32'h0;
            user_dr_reg     <= 32'h0;
            user_update_reg <= 1'b0;
            tdo_reg         <= 1'b0;
            tdo_oe_reg      <= 1'b0;
        end else begin
            user_update_reg <= 1'b0;
            if (trst_active) begin
                ir_reg     <= INSTR_IDCODE;
                tdo_oe_reg <= 1'b0;
            end else begin
                // Actions are keyed on the state the edge is leaving.
                if (tck_rise) begin
                    case (state_reg)
                        TLR:    ir_reg       <= INSTR_IDCODE;
                        CAP_IR: ir_shift_reg <= 4'b0001;
                        SH_IR:  ir_shift_reg <= {tdi_s, ir_shift_reg[3:1]};
                        UPD_IR: ir_reg       <= ir_shift_reg;
                        CAP_DR: dr_shift_reg <= is_idcode ? IDCODE_VALUE :
                                                is_user   ? USER_CAPTURE : 32'h0;
                        SH_DR: begin
                            if (is_bypass) dr_shift_reg[0] <= tdi_s;
                            else           dr_shift_reg    <= {tdi_s, dr_shift_reg[31:1]};
                        end
                        UPD_DR: begin
                            if (is_user) begin
                                user_dr_reg     <= dr_shift_reg;
                                user_update_reg <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (tck_fall) begin
                    tdo_reg    <= (state_reg == SH_IR) ? ir_shift_reg[0] : dr_shift_reg[0];
                    tdo_oe_reg <= (state_reg == SH_DR) || (state_reg == SH_IR);
                end
            end
        end
    end

    assign TDO         = tdo_reg;
    assign TDO_OE      = tdo_oe_reg;
    assign USER_DR     = user_dr_reg;
    assign USER_UPDATE = user_update_reg;
    assign TAP_STATE   = state_reg;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: bit-banged JTAG host with a state-walk
// vector table and hand-written IDCODE/BYPASS/USERDATA/nTRST sequences.
module tb_jtag_tap_responder;

    logic        CLK = 1'b0;
    logic        nRST, TCK, TMS, TDI, nTRST;
    logic        TDO, TDO_OE, USER_UPDATE;
    logic [31:0] USER_CAPTURE, USER_DR;
    logic [3:0]  TAP_STATE;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_count = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (USER_UPDATE === 1'b1) upd_count++;

    jtag_tap_responder dut (
        .CLK(CLK), .nRST(nRST), .TCK(TCK), .TMS(TMS), .TDI(TDI), .nTRST(nTRST),
        .TDO(TDO), .TDO_OE(TDO_OE), .USER_CAPTURE(USER_CAPTURE), .USER_DR(USER_DR),
        .USER_UPDATE(USER_UPDATE), .TAP_STATE(TAP_STATE)
    );

    typedef struct packed {
        logic       tms;
        logic [3:0] exp_state;
    } walk_vec_t;

    walk_vec_t walk [44];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // One TCK period; TDO/TDO_OE are sampled just before the rising edge.
    task automatic jtag_bit(input logic tms, input logic tdi, output logic tdo_s, output logic oe_s);
        tdo_s = TDO;
        oe_s  = TDO_OE;
        TMS = tms;
        TDI = tdi;
        repeat (2) @(negedge CLK);
        TCK = 1'b1;
        repeat (4) @(negedge CLK);
        TCK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic goto_tlr();
        logic t, o;
        for (int i = 0; i < 5; i++) jtag_bit(1'b1, 1'b0, t, o);
    endtask

    // From RTI: load an IR value, return the captured IR bits, end in RTI.
    task automatic shift_ir(input logic [3:0] ir, output logic [3:0] cap);
        logic t, o;
        jtag_bit(1'b1, 1'b0, t, o);
        jtag_bit(1'b1, 1'b0, t, o);
        jtag_bit(1'b0, 1'b0, t, o);
        jtag_bit(1'b0, 1'b0, t, o);
        for (int i = 0; i < 4; i++) begin
            jtag_bit(i == 3, ir[i], t, o);
            cap[i] = t;
        end
        jtag_bit(1'b1, 1'b0, t, o);
        jtag_bit(1'b0, 1'b0, t, o);
    endtask

    // From RTI: shift n DR bits LSB-first, pass Update-DR, end in RTI.
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                            output int oe_cnt);
        logic t, o;
        dout   = 32'h0;
        oe_cnt = 0;
        jtag_bit(1'b1, 1'b0, t, o); if (o) oe_cnt++;
        jtag_bit(1'b0, 1'b0, t, o); if (o) oe_cnt++;
        jtag_bit(1'b0, 1'b0, t, o); if (o) oe_cnt++;
        for (int i = 0; i < n; i++) begin
            jtag_bit(i == n - 1, din[i], t, o);
            dout[i] = t;
            if (o) oe_cnt++;
        end
        jtag_bit(1'b1, 1'b0, t, o); if (o) oe_cnt++;
        jtag_bit(1'b0, 1'b0, t, o); if (o) oe_cnt++;
    endtask

    initial begin
        logic [31:0] dout;
        logic [3:0]  cap;
        logic        t, o;
        int          oe_cnt, upd_before;

        walk[0]  = '{1'b1, 4'hF}; walk[1]  = '{1'b0, 4'hC}; walk[2]  = '{1'b0, 4'hC};
        walk[3]  = '{1'b1, 4'h7}; walk[4]  = '{1'b0, 4'h6}; walk[5]  = '{1'b1, 4'h1};
        walk[6]  = '{1'b0, 4'h3}; walk[7]  = '{1'b0, 4'h3}; walk[8]  = '{1'b1, 4'h0};
        walk[9]  = '{1'b0, 4'h2}; walk[10] = '{1'b0, 4'h2}; walk[11] = '{1'b1, 4'h1};
        walk[12] = '{1'b1, 4'h5}; walk[13] = '{1'b1, 4'h7}; walk[14] = '{1'b0, 4'h6};
        walk[15] = '{1'b0, 4'h2}; walk[16] = '{1'b1, 4'h1}; walk[17] = '{1'b0, 4'h3};
        walk[18] = '{1'b1, 4'h0}; walk[19] = '{1'b1, 4'h5}; walk[20] = '{1'b0, 4'hC};
        walk[21] = '{1'b1, 4'h7}; walk[22] = '{1'b1, 4'h4}; walk[23] = '{1'b0, 4'hE};
        walk[24] = '{1'b1, 4'h9}; walk[25] = '{1'b0, 4'hB}; walk[26] = '{1'b0, 4'hB};
        walk[27] = '{1'b1, 4'h8}; walk[28] = '{1'b0, 4'hA}; walk[29] = '{1'b0, 4'hA};
        walk[30] = '{1'b1, 4'h9}; walk[31] = '{1'b1, 4'hD}; walk[32] = '{1'b1, 4'h7};
        walk[33] = '{1'b1, 4'h4}; walk[34] = '{1'b0, 4'hE}; walk[35] = '{1'b0, 4'hA};
        walk[36] = '{1'b1, 4'h9}; walk[37] = '{1'b0, 4'hB}; walk[38] = '{1'b1, 4'h8};
        walk[39] = '{1'b1, 4'hD}; walk[40] = '{1'b0, 4'hC}; walk[41] = '{1'b1, 4'h7};
        walk[42] = '{1'b1, 4'h4}; walk[43] = '{1'b1, 4'hF};

        nRST = 1'b0; TCK = 1'b0; TMS = 1'b1; TDI = 1'b0; nTRST = 1'b1;
        USER_CAPTURE = 32'hCAFE_F00D;
        repeat (3) @(negedge CLK);
        check("reset_state", {28'h0, TAP_STATE}, 32'hF);
        check("reset_tdo", {31'h0, TDO}, 32'h0);
        check("reset_oe", {31'h0, TDO_OE}, 32'h0);
        check("reset_user_dr", USER_DR, 32'h0);
        check("reset_update", {31'h0, USER_UPDATE}, 32'h0);
        nRST = 1'b1;
        repeat (4) @(negedge CLK);

        goto_tlr();
        check("tlr_state", {28'h0, TAP_STATE}, 32'hF);
        check("tlr_oe", {31'h0, TDO_OE}, 32'h0);
        check("tlr_user_dr", USER_DR, 32'h0);

        jtag_bit(1'b0, 1'b0, t, o);
        check("rti_state", {28'h0, TAP_STATE}, 32'hC);
        shift_dr(32, 32'h0, dout, oe_cnt);
        check("idcode_tdo", dout, 32'h1234_5679);
        check("idcode_oe_cycles", oe_cnt, 32);

        shift_ir(4'b1111, cap);
        check("ir_capture", {28'h0, cap}, 32'h1);
        shift_dr(8, 32'h0000_00B3, dout, oe_cnt);
        check("bypass_tdo", dout, 32'h0000_0066);
        check("bypass_oe_cycles", oe_cnt, 8);

        shift_ir(4'b0101, cap);
        shift_dr(8, 32'h0000_005C, dout, oe_cnt);
        check("unknown_ir_bypass", dout, 32'h0000_00B8);

        shift_ir(4'b1000, cap);
        check("ir_capture2", {28'h0, cap}, 32'h1);
        upd_before = upd_count;
        shift_dr(32, 32'hA5A5_0F0F, dout, oe_cnt);
        check("user_capture_tdo", dout, 32'hCAFE_F00D);
        check("user_dr", USER_DR, 32'hA5A5_0F0F);
        check("user_update_cycles", upd_count - upd_before, 1);

        // nTRST asserted mid-shift under USERDATA.
        jtag_bit(1'b1, 1'b0, t, o);
        jtag_bit(1'b0, 1'b0, t, o);
        jtag_bit(1'b0, 1'b0, t, o);
        for (int i = 0; i < 10; i++) jtag_bit(1'b0, 1'b1, t, o);
        check("pre_trst_oe", {31'h0, TDO_OE}, 32'h1);
        upd_before = upd_count;
        nTRST = 1'b0;
        repeat (3) @(negedge CLK);
        check("trst_state", {28'h0, TAP_STATE}, 32'hF);
        check("trst_oe", {31'h0, TDO_OE}, 32'h0);
        repeat (5) @(negedge CLK);
        nTRST = 1'b1;
        repeat (4) @(negedge CLK);
        jtag_bit(1'b0, 1'b0, t, o);
        shift_dr(32, 32'hFFFF_FFFF, dout, oe_cnt);
        check("trst_ir_idcode", dout, 32'h1234_5679);
        check("trst_user_dr_kept", USER_DR, 32'hA5A5_0F0F);
        check("trst_no_update", upd_count - upd_before, 0);

        goto_tlr();
        for (int i = 0; i < 44; i++) begin
            jtag_bit(walk[i].tms, 1'b0, t, o);
            check($sformatf("walk[%0d] tms=%0d", i, walk[i].tms),
                  {28'h0, TAP_STATE}, {28'h0, walk[i].exp_state});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
